// File: rtl/sect233k1_scalar_loader.sv
// Loads a 256-bit scalar as eight 32-bit words, range-checks it for sect233k1 and hands it to a point
// multiplier, then streams the (x, y) result back as sixteen 32-bit words. Optional WAIT watchdog: SECT233K1_SCALAR_LOADER_TIMEOUT_EN.
module sect233k1_scalar_loader #(
  parameter int unsigned M           = 233,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [31:0]  wr_data,
  output logic         busy,
  output logic         err,
  output logic         pm_start,
  output logic [M-1:0] pm_d,
  input  logic         pm_done,
  input  logic [M-1:0] pm_x,
  input  logic [M-1:0] pm_y,
  input  logic         rd_en,
  output logic         rd_valid,
  output logic [31:0]  rd_data
);

  localparam int unsigned SW = 256;
  localparam int unsigned RW = 2 * SW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // Reject widths the word packing cannot represent.
  if (M == 0 || M >= SW || TIMEOUT_CYC == 0) begin : g_bad_cfg
    $error("sect233k1_scalar_loader: unsupported M or TIMEOUT_CYC");
  end

  logic [2:0]    state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [3:0]    rptr, rptr_nxt;
  logic [SW-1:0] scalar, scalar_nxt;
  logic [RW-1:0] result, result_nxt;
  logic          busy_nxt, err_nxt, pm_start_nxt, rd_valid_nxt;
  logic [31:0]   rd_data_nxt;
`ifdef SECT233K1_SCALAR_LOADER_TIMEOUT_EN
  logic [31:0]   wait_cnt, wait_cnt_nxt;
`endif

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rptr_nxt   = rptr;
    scalar_nxt = scalar;
    result_nxt = result;
`ifdef SECT233K1_SCALAR_LOADER_TIMEOUT_EN
    wait_cnt_nxt = wait_cnt;
`endif
    case (state)
      S_IDLE, S_LOAD: begin
        if (wr_en) begin
          scalar_nxt[{cnt, 5'b0} +: 32] = wr_data;
          cnt_nxt   = cnt + 3'd1;
          state_nxt = (cnt == 3'd7) ? S_CHECK : S_LOAD;
        end
      end
      S_CHECK: begin
        if ((|scalar[SW-1:M]) || (scalar == '0)) state_nxt = S_ERR;
        else                                     state_nxt = S_START;
      end
      S_START: begin
        state_nxt = S_WAIT;
`ifdef SECT233K1_SCALAR_LOADER_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end
      S_WAIT: begin
        // A done in the limit cycle still wins over the watchdog.
        if (pm_done) begin
          result_nxt = {SW'(pm_y), SW'(pm_x)};
          state_nxt  = S_READ;
        end
`ifdef SECT233K1_SCALAR_LOADER_TIMEOUT_EN
        else if (wait_cnt == 32'(TIMEOUT_CYC - 1)) state_nxt = S_ERR;
        else                                       wait_cnt_nxt = wait_cnt + 32'd1;
`endif
      end
      S_READ: begin
        if (rd_en && rd_valid) begin
          rptr_nxt = rptr + 4'd1;
          if (rptr == 4'd15) state_nxt = S_IDLE;
        end
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase

    if (clr) begin
      state_nxt  = S_IDLE;
      cnt_nxt    = '0;
      rptr_nxt   = '0;
      scalar_nxt = '0;
      result_nxt = '0;
`ifdef SECT233K1_SCALAR_LOADER_TIMEOUT_EN
      wait_cnt_nxt = '0;
`endif
    end

    busy_nxt     = (state_nxt != S_IDLE);
    err_nxt      = (state_nxt == S_ERR);
    pm_start_nxt = (state_nxt == S_START);
    rd_valid_nxt = (state_nxt == S_READ);
    rd_data_nxt  = rd_valid_nxt ? result_nxt[{rptr_nxt, 5'b0} +: 32] : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rptr     <= '0;
      scalar   <= '0;
      result   <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      pm_start <= 1'b0;
      pm_d     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
`ifdef SECT233K1_SCALAR_LOADER_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rptr     <= rptr_nxt;
      scalar   <= scalar_nxt;
      result   <= result_nxt;
      busy     <= busy_nxt;
      err      <= err_nxt;
      pm_start <= pm_start_nxt;
      pm_d     <= scalar_nxt[M-1:0];
      rd_valid <= rd_valid_nxt;
      rd_data  <= rd_data_nxt;
`ifdef SECT233K1_SCALAR_LOADER_TIMEOUT_EN
      wait_cnt <= wait_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sect233k1_scalar_loader.sv
// Self-checking bench for sect233k1_scalar_loader: vector table, hand-written corner sequences and
// randomized transactions against a behavioural model. Timeout checks run when SECT233K1_SCALAR_LOADER_TIMEOUT_EN is defined.
module tb_sect233k1_scalar_loader;

  localparam int unsigned M  = 233;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst, clr, wr_en, pm_done, rd_en;
  logic [31:0]   wr_data;
  logic          busy, err, pm_start, rd_valid;
  logic [M-1:0]  pm_d, pm_x, pm_y;
  logic [31:0]   rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string        name;
    logic [255:0] sc;
    logic         exp_err;
    logic [M-1:0] x;
    logic [M-1:0] y;
  } vec_t;

  vec_t tbl[7];

  sect233k1_scalar_loader #(.M(M), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .err(err), .pm_start(pm_start), .pm_d(pm_d),
    .pm_done(pm_done), .pm_x(pm_x), .pm_y(pm_y),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scalar is legal for the curve when nonzero and below 2^233.
  function automatic logic model_err(input logic [255:0] sc);
    return ((sc >> M) != 256'd0) || (sc == 256'd0);
  endfunction

  // Result stream: x then y, each as a 256-bit little-endian word sequence.
  function automatic logic [31:0] exp_word(input logic [M-1:0] x, input logic [M-1:0] y, input int k);
    logic [511:0] full;
    full = (512'(y) << 256) | 512'(x);
    return full[32*k +: 32];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
    return t;
  endfunction

  function automatic logic [M-1:0] rand_coord();
    logic [255:0] t;
    t = rand256();
    return t[M-1:0];
  endfunction

  // Starts at a negedge in IDLE; returns at the negedge of the CHECK cycle.
  task automatic load(input string name, input logic [255:0] sc);
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = sc[32*i +: 32];
      @(negedge clk);
      if (i == 0) chk({name, " busy_after_first_write"}, 256'(busy), 256'd1);
    end
    wr_en = 1'b0;
  endtask

  task automatic clear_from_err(input string name);
    repeat (3) begin
      wr_en   = 1'b1;
      wr_data = $urandom;
      @(negedge clk);
    end
    chk({name, " err_held"}, 256'(err), 256'd1);
    chk({name, " no_start_in_err"}, 256'(pm_start), 256'd0);
    clr = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    wr_en = 1'b0;
    chk({name, " err_after_clr"}, 256'(err), 256'd0);
    chk({name, " busy_after_clr"}, 256'(busy), 256'd0);
    chk({name, " pm_d_after_clr"}, 256'(pm_d), 256'd0);
  endtask

  task automatic run_txn(input string name, input logic [255:0] sc, input logic exp_err,
                         input logic [M-1:0] x, input logic [M-1:0] y, input int stall_at);
    int k, cyc, stall_left, d;
    logic pop;
    load(name, sc);
    chk({name, " check_no_start"}, 256'(pm_start), 256'd0);
    @(negedge clk);
    if (exp_err) begin
      chk({name, " err"}, 256'(err), 256'd1);
      chk({name, " no_start"}, 256'(pm_start), 256'd0);
      clear_from_err(name);
      return;
    end
    chk({name, " start"}, 256'(pm_start), 256'd1);
    chk({name, " err_low"}, 256'(err), 256'd0);
    chk({name, " pm_d"}, 256'(pm_d), 256'(sc[M-1:0]));
    @(negedge clk);
    chk({name, " start_one_cycle"}, 256'(pm_start), 256'd0);
    d = $urandom_range(0, 12);
    repeat (d) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_data = $urandom;
      @(negedge clk);
    end
    wr_en   = 1'b0;
    pm_done = 1'b1;
    pm_x    = x;
    pm_y    = y;
    @(negedge clk);
    pm_done = 1'b0;
    pm_x    = rand_coord();
    pm_y    = rand_coord();
    chk({name, " rd_valid"}, 256'(rd_valid), 256'd1);
    k = 0; cyc = 0; stall_left = 5;
    while (k < 16 && cyc < 400) begin
      chk({name, " rd_valid_stream"}, 256'(rd_valid), 256'd1);
      chk($sformatf("%s rd_data[%0d]", name, k), 256'(rd_data), 256'(exp_word(x, y, k)));
      if (stall_at >= 0 && k == stall_at && stall_left > 0) begin
        pop = 1'b0;
        stall_left--;
      end else begin
        pop = ($urandom_range(0, 3) != 0);
      end
      rd_en   = pop;
      wr_en   = 1'($urandom_range(0, 1));
      wr_data = $urandom;
      @(negedge clk);
      cyc++;
      if (pop) k++;
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk({name, " read_complete"}, 256'(k), 256'd16);
    chk({name, " pm_d_stable"}, 256'(pm_d), 256'(sc[M-1:0]));
    chk({name, " rd_valid_done"}, 256'(rd_valid), 256'd0);
    chk({name, " idle_after_read"}, 256'(busy), 256'd0);
  endtask

  initial begin
    logic [255:0] sc;
    logic [255:0] t;

    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_data = '0;
    pm_done = 1'b0; pm_x = '0; pm_y = '0; rd_en = 1'b0;

    t = {32'h000001ff, 32'hdeadbeef, 32'h01234567, 32'h89abcdef,
         32'hcafef00d, 32'h0badf00d, 32'h5555aaaa, 32'h00000126};
    tbl[0] = '{"one", 256'd1, 1'b0, t[M-1:0], M'(0)};
    t = {32'h00000155, 32'h11111111, 32'h22222222, 32'h33333333,
         32'h44444444, 32'h55555555, 32'h66666666, 32'h000006a3};
    tbl[0].y = t[M-1:0];
    tbl[1] = '{"zero", 256'd0, 1'b1, rand_coord(), rand_coord()};
    tbl[2] = '{"bit233", {32'h00000200, {7{32'h00000001}}}, 1'b1, rand_coord(), rand_coord()};
    tbl[3] = '{"max_word7", {32'h000001ff, {7{32'h00000000}}}, 1'b0, rand_coord(), rand_coord()};
    tbl[4] = '{"all_ones_233", {32'h000001ff, {7{32'hffffffff}}}, 1'b0, rand_coord(), rand_coord()};
    tbl[5] = '{"bit255", {32'h80000000, {7{32'h00000000}}}, 1'b1, rand_coord(), rand_coord()};
    tbl[6] = '{"bit232", {32'h00000100, {7{32'h00000000}}}, 1'b0, rand_coord(), rand_coord()};

    repeat (2) @(negedge clk);
    chk("reset busy", 256'(busy), 256'd0);
    chk("reset err", 256'(err), 256'd0);
    chk("reset pm_start", 256'(pm_start), 256'd0);
    chk("reset pm_d", 256'(pm_d), 256'd0);
    chk("reset rd_valid", 256'(rd_valid), 256'd0);
    chk("reset rd_data", 256'(rd_data), 256'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_txn(tbl[i].name, tbl[i].sc, tbl[i].exp_err, tbl[i].x, tbl[i].y, -1);

    // Five-cycle rd_en gap mid-stream.
    run_txn("stall", 256'd12345, 1'b0, rand_coord(), rand_coord(), 6);

    // Clear during WAIT abandons the multiplication; late done is ignored.
    load("clr_wait", 256'd5);
    @(negedge clk);
    @(negedge clk);
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_wait busy", 256'(busy), 256'd0);
    chk("clr_wait pm_d", 256'(pm_d), 256'd0);
    repeat (9) @(negedge clk);
    pm_done = 1'b1; pm_x = rand_coord(); pm_y = rand_coord();
    @(negedge clk);
    pm_done = 1'b0;
    chk("clr_wait rd_valid", 256'(rd_valid), 256'd0);
    chk("clr_wait busy_late_done", 256'(busy), 256'd0);
    chk("clr_wait rd_data", 256'(rd_data), 256'd0);

    // pm_done in IDLE is ignored.
    pm_done = 1'b1;
    @(negedge clk);
    pm_done = 1'b0;
    chk("idle_done busy", 256'(busy), 256'd0);
    chk("idle_done rd_valid", 256'(rd_valid), 256'd0);

    // Asynchronous reset takes effect before the next clock edge.
    load("async_rst", 256'd3);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst busy", 256'(busy), 256'd0);
    chk("async_rst pm_d", 256'(pm_d), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("async_rst held_idle", 256'(busy), 256'd0);
    run_txn("after_rst", 256'd7, 1'b0, rand_coord(), rand_coord(), -1);

    for (int i = 0; i < 40; i++) begin
      sc = rand256();
      if ($urandom_range(0, 1) == 0) sc[255:M] = '0;
      if ($urandom_range(0, 7) == 0) sc = '0;
      run_txn($sformatf("rand%0d", i), sc, model_err(sc), rand_coord(), rand_coord(), -1);
    end

`ifdef SECT233K1_SCALAR_LOADER_TIMEOUT_EN
    load("timeout", 256'd1);
    @(negedge clk);
    @(negedge clk);
    repeat (15) @(negedge clk);
    chk("timeout err_before_limit", 256'(err), 256'd0);
    @(negedge clk);
    chk("timeout err", 256'(err), 256'd1);
    clear_from_err("timeout");
    load("done_at_limit", 256'd1);
    @(negedge clk);
    @(negedge clk);
    repeat (15) @(negedge clk);
    pm_done = 1'b1; pm_x = tbl[0].x; pm_y = tbl[0].y;
    @(negedge clk);
    pm_done = 1'b0;
    chk("done_at_limit rd_valid", 256'(rd_valid), 256'd1);
    chk("done_at_limit err", 256'(err), 256'd0);
    chk("done_at_limit word0", 256'(rd_data), 256'(exp_word(tbl[0].x, tbl[0].y, 0)));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("done_at_limit clr", 256'(busy), 256'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
